mem_wb_multi: RTL and testbench
===============================

Name: mem_wb_multi

Overview:
Parametrised MEM/WB pipeline register, successor to the single-lane MEM/WB latch. Carries NUM_CH parallel write-back lanes with per-lane valid, and uses a generic stall-vector index so it can sit at any stage boundary. Adds flush, same-cycle write-conflict resolution and x0 write suppression. Sits between the memory-access stage and the register-file write ports.

Parameters:
NUM_CH, 2, number of write-back lanes (1..4)
DATA_W, 32, register data width per lane
ADDR_W, 5, register address width per lane
STALL_W, 6, width of the pipeline stall vector
STALL_IDX, 4, stall bit owned by this stage; STALL_IDX+1 is the downstream bit; legal range 0..STALL_W-2
ZERO_SUPPRESS, 1, 1 = force wreg low for any lane whose address is 0
CNT_W, 64, retire counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
stall  in  STALL_W  pipeline stall vector
flush  in  1  kill the incoming instruction group (exception/redirect)
mem_valid  in  NUM_CH  per-lane instruction valid from MEM
mem_wd  in  NUM_CH*ADDR_W  per-lane destination register; lane i at [i*ADDR_W +: ADDR_W]
mem_wreg  in  NUM_CH  per-lane write enable
mem_wdata  in  NUM_CH*DATA_W  per-lane write data
wb_valid  out  NUM_CH  per-lane valid to WB
wb_wd  out  NUM_CH*ADDR_W  per-lane destination to WB
wb_wreg  out  NUM_CH  per-lane write enable to WB
wb_wdata  out  NUM_CH*DATA_W  per-lane data to WB
wb_commit  out  1  one-cycle pulse: a group with at least one valid lane was loaded last edge

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk): all outputs 0. This includes wb_valid, wb_wd, wb_wreg, wb_wdata and wb_commit, and the counter when the optional feature is present. Reset asserted mid-stall or mid-flush wins unconditionally.
- Latency: 1 cycle. Registered outputs only; no combinational path from inputs to outputs.
- Per-edge priority, highest first:
  1. flush=1 -> bubble.
  2. stall[STALL_IDX]=1 and stall[STALL_IDX+1]=0 -> bubble.
  3. stall[STALL_IDX]=1 and stall[STALL_IDX+1]=1 -> hold all outputs; wb_commit=0.
  4. stall[STALL_IDX]=0 -> load.
- Bubble: every lane's valid, wd, wreg and wdata = 0; wb_commit=0.
- Flush and stall together -> bubble (flush wins).
- Load, per lane i:
  - wb_valid[i] = mem_valid[i].
  - wb_wd and wb_wdata copied unchanged.
  - wb_wreg[i] = mem_wreg[i] & mem_valid[i] & ~kill[i].
- kill[i] is set when either:
  - ZERO_SUPPRESS=1 and lane address == 0; or
  - some higher-numbered lane j>i has mem_valid[j]&mem_wreg[j] and the same address (last-lane-wins, matching program order).
- Lanes with mem_valid=0 load wreg=0 but still pass wd/wdata through (don't-care for WB; verification checks wreg only).
- wb_commit = 1 for exactly the cycle after a load edge where |mem_valid=1. A hold keeps wb_commit at 0 and does not repeat the pulse.
- stall bits other than STALL_IDX and STALL_IDX+1 are ignored.

Optional Feature:
Macro MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt (CNT_W bits), reset to 0.
  - On every load edge, increments by popcount(mem_valid) (0..NUM_CH).
  - Flush, bubble and hold edges do not increment.
  - Wraps modulo 2^CNT_W with no saturation or flag.
  - Reads as the count including the group currently presented on the wb_* outputs.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 asynchronously between edges with nonzero inputs -> all outputs 0 immediately; release rst, first load edge with lane0 wd=5, wdata=0xDEADBEEF, valid=1, wreg=1 -> wb_wd lane0=5, wb_wdata=0xDEADBEEF, wb_wreg=1, wb_commit=1 next cycle.
- Stall bubble vs hold: stall=6'b010000 -> outputs zeroed; stall=6'b110000 with prior group lane1 wd=7, wdata=0x1234 -> lane1 outputs unchanged for 3 cycles, wb_commit=0 throughout.
- Flush priority: flush=1 with stall=6'b110000 and valid inputs -> bubble (all zero), not hold.
- Conflict and x0: lane0 and lane1 both wd=9, wreg=1, valid=1 -> wb_wreg=2'b10. Lane0 wd=0, wreg=1 with ZERO_SUPPRESS=1 -> wb_wreg[0]=0 while wb_valid[0]=1.
- Invalid lane: mem_valid=2'b01, mem_wreg=2'b11 -> wb_wreg=2'b01, wb_valid=2'b01.
- With MEM_WB_RETIRE_CNT_EN: 10 loads of valid=2'b11, 1 flush, 2 bubbles, 3 holds -> retire_cnt=20. With CNT_W=4 preloaded near the top, after crossing 15 -> value wraps modulo 16.

Source files
------------

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM/WB pipeline register with flush, stall bubble/hold, same-cycle write-conflict
// resolution and x0 write suppression. Optional retire counter enabled by MEM_WB_RETIRE_CNT_EN.
module mem_wb_multi #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int STALL_W       = 6,
    parameter int STALL_IDX     = 4,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        mem_valid,
    input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    output logic [NUM_CH-1:0]        wb_valid,
    output logic [NUM_CH*ADDR_W-1:0] wb_wd,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic                     wb_commit
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]         retire_cnt
`endif
);

    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic [NUM_CH*ADDR_W-1:0] wd_q, wd_d;
    logic [NUM_CH-1:0]        wreg_q, wreg_d;
    logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;
    logic                     commit_q, commit_d;
    logic [NUM_CH-1:0]        kill;

    logic stall_own;
    logic stall_dn;
    logic do_bubble;
    logic do_hold;
    logic do_load;
    logic stall_unused;

    assign stall_own    = stall[STALL_IDX];
    assign stall_dn     = stall[STALL_IDX+1];
    assign stall_unused = ^stall;

    // Flush outranks everything; a stalled stage with a free downstream emits a bubble.
    assign do_bubble = flush | (stall_own & ~stall_dn);
    assign do_hold   = ~flush & stall_own & stall_dn;
    assign do_load   = ~flush & ~stall_own;

    // A lane loses its write if it targets x0 or a later lane in the group writes the same register.
    always_comb begin
        kill = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((ZERO_SUPPRESS != 0) && (mem_wd[i*ADDR_W +: ADDR_W] == '0)) begin
                kill[i] = 1'b1;
            end
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (mem_valid[j] && mem_wreg[j] &&
                    (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
                    kill[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        commit_d = 1'b0;
        if (do_bubble) begin
            valid_d = '0;
            wd_d    = '0;
            wreg_d  = '0;
            wdata_d = '0;
        end else if (do_load) begin
            valid_d  = mem_valid;
            wd_d     = mem_wd;
            wdata_d  = mem_wdata;
            wreg_d   = mem_wreg & mem_valid & ~kill;
            commit_d = |mem_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            wd_q     <= '0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            commit_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            commit_q <= commit_d;
        end
    end

    assign wb_valid  = valid_q;
    assign wb_wd     = wd_q;
    assign wb_wreg   = wreg_q;
    assign wb_wdata  = wdata_q;
    assign wb_commit = commit_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pop;

    // Counts every valid lane loaded; wraps silently.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + CNT_W'(mem_valid[i]);
        end
        cnt_d = do_load ? (cnt_q + pop) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench for mem_wb_multi: directed scenarios plus randomized traffic against a
// rule-level reference model (last-writer table per register, popcount retire total).
module tb_mem_wb_multi;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int STALL_W   = 6;
  localparam int STALL_IDX = 4;
  localparam int CNT_W     = 4;
  localparam int VEC_W     = 2*NUM_CH + NUM_CH*ADDR_W + NUM_CH*DATA_W + 1;

  logic                     clk;
  logic                     rst;
  logic [STALL_W-1:0]       stall;
  logic                     flush;
  logic [NUM_CH-1:0]        mem_valid;
  logic [NUM_CH*ADDR_W-1:0] mem_wd;
  logic [NUM_CH-1:0]        mem_wreg;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic [NUM_CH-1:0]        wb_valid;
  logic [NUM_CH*ADDR_W-1:0] wb_wd;
  logic [NUM_CH-1:0]        wb_wreg;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic                     wb_commit;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0]         retire_cnt;
`endif

  int n_pass;
  int n_total;

  // reference model state
  logic [NUM_CH-1:0]        m_valid;
  logic [NUM_CH*ADDR_W-1:0] m_wd;
  logic [NUM_CH-1:0]        m_wreg;
  logic [NUM_CH*DATA_W-1:0] m_wdata;
  logic                     m_commit;
  int                       m_cnt;

  mem_wb_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
    .STALL_IDX(STALL_IDX), .ZERO_SUPPRESS(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_commit(wb_commit)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [VEC_W-1:0] obs_vec();
    return {wb_valid, wb_wreg, wb_wd, wb_wdata, wb_commit};
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    return {m_valid, m_wreg, m_wd, m_wdata, m_commit};
  endfunction

  task automatic model_reset();
    m_valid = '0; m_wd = '0; m_wreg = '0; m_wdata = '0; m_commit = 1'b0; m_cnt = 0;
  endtask

  // Applies the edge rules to the inputs currently driven.
  task automatic model_edge();
    int last_writer[32];
    for (int a = 0; a < 32; a++) last_writer[a] = -1;
    if (flush || (stall[STALL_IDX] && !stall[STALL_IDX+1])) begin
      m_valid = '0; m_wd = '0; m_wreg = '0; m_wdata = '0; m_commit = 1'b0;
    end else if (stall[STALL_IDX]) begin
      m_commit = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (mem_valid[i] && mem_wreg[i]) last_writer[int'(mem_wd[i*ADDR_W +: ADDR_W])] = i;
      for (int i = 0; i < NUM_CH; i++) begin
        int addr;
        addr = int'(mem_wd[i*ADDR_W +: ADDR_W]);
        m_valid[i] = mem_valid[i];
        m_wreg[i]  = mem_valid[i] && mem_wreg[i] && (addr != 0) && (last_writer[addr] == i);
        if (mem_valid[i]) m_cnt = m_cnt + 1;
      end
      m_wd     = mem_wd;
      m_wdata  = mem_wdata;
      m_commit = |mem_valid;
    end
  endtask

  // driver tasks
  task automatic drive(input logic fl, input logic [STALL_W-1:0] st, input logic [NUM_CH-1:0] v,
                       input logic [ADDR_W-1:0] wd0, input logic [ADDR_W-1:0] wd1,
                       input logic [NUM_CH-1:0] wr, input logic [DATA_W-1:0] d0,
                       input logic [DATA_W-1:0] d1);
    flush = fl; stall = st; mem_valid = v; mem_wreg = wr;
    mem_wd = {wd1, wd0};
    mem_wdata = {d1, d0};
  endtask

  task automatic drive_random();
    drive(1'b0, STALL_W'($urandom_range(0, 63)), NUM_CH'($urandom_range(0, 3)),
          ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3)),
          NUM_CH'($urandom_range(0, 3)), $urandom, $urandom);
    flush = ($urandom_range(0, 9) == 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive(1'b0, '0, 2'b11, 5'd3, 5'd4, 2'b11, 32'h1111_2222, 32'h3333_4444);
    #12;
    n_total++;
    if (obs_vec() !== '0) $display("FAIL reset_initial: got %h expected 0", obs_vec());
    else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_preload: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    // asynchronous assertion between edges, inputs still nonzero
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (obs_vec() !== '0) $display("FAIL reset_async: got %h expected 0", obs_vec());
    else n_pass++;
`ifdef MEM_WB_RETIRE_CNT_EN
    n_total++;
    if (retire_cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", retire_cnt);
    else n_pass++;
`endif
    #2 rst = 1'b1;
  endtask

  task automatic test_first_load();
    drive(1'b0, '0, 2'b01, 5'd5, 5'd0, 2'b01, 32'hDEAD_BEEF, 32'h0);
    step();
    n_total++;
    if ({wb_wd[4:0], wb_wdata[31:0], wb_wreg[0], wb_commit} !== {5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1})
      $display("FAIL first_load: got wd=%0d data=%h wreg=%b commit=%b expected 5 deadbeef 1 1",
               wb_wd[4:0], wb_wdata[31:0], wb_wreg[0], wb_commit);
    else n_pass++;
    drive(1'b0, '0, 2'b00, 5'd6, 5'd7, 2'b11, 32'h5, 32'h6);
    step();
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL empty_load: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_stall_bubble_hold();
    drive(1'b0, '0, 2'b10, 5'd0, 5'd7, 2'b10, 32'h0, 32'h1234);
    step();
    for (int c = 0; c < 3; c++) begin
      drive_random();
      flush = 1'b0;
      stall = 6'b110000;
      step();
      n_total++;
      if ({wb_wd[9:5], wb_wdata[63:32], wb_valid[1], wb_wreg[1], wb_commit} !==
          {5'd7, 32'h1234, 1'b1, 1'b1, 1'b0})
        $display("FAIL hold_lane1 c%0d: got wd=%0d data=%h v=%b w=%b commit=%b expected 7 1234 1 1 0",
                 c, wb_wd[9:5], wb_wdata[63:32], wb_valid[1], wb_wreg[1], wb_commit);
      else n_pass++;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL hold_all c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b0, 6'b010000, 2'b11, 5'd1, 5'd2, 2'b11, 32'hAA, 32'hBB);
    step();
    n_total++;
    if (obs_vec() !== '0) $display("FAIL stall_bubble: got %h expected 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    drive(1'b0, '0, 2'b11, 5'd8, 5'd9, 2'b11, 32'hC0DE, 32'hF00D);
    step();
    drive(1'b1, 6'b110000, 2'b11, 5'd10, 5'd11, 2'b11, 32'h1, 32'h2);
    step();
    n_total++;
    if (obs_vec() !== '0) $display("FAIL flush_over_hold: got %h expected 0", obs_vec());
    else n_pass++;
    drive(1'b0, '0, 2'b11, 5'd12, 5'd13, 2'b11, 32'h3, 32'h4);
    step();
    drive(1'b1, '0, 2'b11, 5'd14, 5'd15, 2'b11, 32'h5, 32'h6);
    step();
    n_total++;
    if (obs_vec() !== '0) $display("FAIL flush_plain: got %h expected 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_conflict_x0();
    drive(1'b0, '0, 2'b11, 5'd9, 5'd9, 2'b11, 32'h10, 32'h20);
    step();
    n_total++;
    if (wb_wreg !== 2'b10) $display("FAIL conflict_wreg: got %b expected 10", wb_wreg);
    else n_pass++;
    drive(1'b0, '0, 2'b11, 5'd0, 5'd3, 2'b11, 32'h30, 32'h40);
    step();
    n_total++;
    if ({wb_wreg, wb_valid} !== {2'b10, 2'b11})
      $display("FAIL x0_suppress: got wreg=%b valid=%b expected 10 11", wb_wreg, wb_valid);
    else n_pass++;
    // an invalid later lane must not kill an earlier writer
    drive(1'b0, '0, 2'b01, 5'd6, 5'd6, 2'b11, 32'h50, 32'h60);
    step();
    n_total++;
    if (wb_wreg !== 2'b01) $display("FAIL conflict_invalid_later: got %b expected 01", wb_wreg);
    else n_pass++;
  endtask

  task automatic test_invalid_lane();
    drive(1'b0, 6'b001111, 2'b01, 5'd1, 5'd2, 2'b11, 32'h70, 32'h80);
    step();
    n_total++;
    if ({wb_wreg, wb_valid} !== {2'b01, 2'b01})
      $display("FAIL invalid_lane: got wreg=%b valid=%b expected 01 01", wb_wreg, wb_valid);
    else n_pass++;
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL invalid_lane_all: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive_random();
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else n_pass++;
`ifdef MEM_WB_RETIRE_CNT_EN
      n_total++;
      if (retire_cnt !== CNT_W'(m_cnt))
        $display("FAIL random_cnt c%0d: got %0d expected %0d", c, retire_cnt, CNT_W'(m_cnt));
      else n_pass++;
`endif
    end
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, '0, 2'b11, ADDR_W'(c + 1), ADDR_W'(c + 2), 2'b11, $urandom, $urandom);
      step();
    end
    drive(1'b1, '0, 2'b11, 5'd1, 5'd2, 2'b11, 32'h1, 32'h2);
    step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 6'b010000, 2'b11, 5'd1, 5'd2, 2'b11, 32'h1, 32'h2);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 6'b110000, 2'b11, 5'd1, 5'd2, 2'b11, 32'h1, 32'h2);
      step();
    end
    // 20 retired lanes wrap modulo 16 with a 4-bit counter
    n_total++;
    if (retire_cnt !== CNT_W'(20 % 16)) $display("FAIL retire_total: got %0d expected 4", retire_cnt);
    else n_pass++;
    n_total++;
    if (retire_cnt !== CNT_W'(m_cnt)) $display("FAIL retire_model: got %0d expected %0d", retire_cnt, CNT_W'(m_cnt));
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_first_load();
    test_stall_bubble_hold();
    test_flush_priority();
    test_conflict_x0();
    test_invalid_lane();
`ifdef MEM_WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
